fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/cpu_pkg.sv | 6 +
 rtl/fq_mem.sv | 19 +
 rtl/fetch_queue.sv | 66 ++++++
 tb/tb_fetch_queue.sv | 118 +++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and defaults for the fetch path
package cpu_pkg;
  localparam int ADDR_W = 30;
  localparam int INSTR_W = 32;
  localparam int FQ_DEPTH = 4;
endpackage

// File: rtl/fq_mem.sv
// fq_mem: DEPTH x W storage with one synchronous write port and one combinational read port
//   clk, we/waddr/wdata: write on rising edge when we=1
//   raddr/rdata: asynchronous read of the addressed entry
module fq_mem #(
  parameter int DEPTH = 4,
  parameter int W = 62
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (we) r_mem[waddr] <= wdata;
  assign rdata = r_mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO that fetches sequentially from imem and supports redirects
//   clk, rst (sync, active-high), flush/flush_addr: redirect to a new word address
//   imem_addr/imem_data: registered fetch address, same-cycle instruction return
//   out_valid/out_ready/out_instr/out_pc/out_pc_next: head entry handshake to decode
//   count: occupied entries
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int                DEPTH = FQ_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          flush_addr,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_pc_next,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [ADDR_W-1:0]     r_fetch_pc;
  logic                  w_push, w_pop;
  logic [INSTR_W+ADDR_W-1:0] w_rdata;
  assign out_valid = r_count != '0;
  assign w_pop = out_valid & out_ready & ~flush;
  // a full queue can still accept a fetch when the head leaves the same cycle
  assign w_push = ~flush & (r_count != CW'(DEPTH) | w_pop);
  always_ff @(posedge clk)
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_fetch_pc <= flush_addr;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_push) r_fetch_pc <= r_fetch_pc + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  fq_mem #(.DEPTH(DEPTH), .W(INSTR_W + ADDR_W)) u_mem (
    .clk  (clk),
    .we   (w_push),
    .waddr(r_wr_ptr),
    .wdata({imem_data, r_fetch_pc}),
    .raddr(r_rd_ptr),
    .rdata(w_rdata)
  );
  assign imem_addr = r_fetch_pc;
  assign out_instr = w_rdata[INSTR_W+ADDR_W-1:ADDR_W];
  assign out_pc = w_rdata[ADDR_W-1:0];
  assign out_pc_next = out_pc + 1'b1;
  assign count = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue
module tb_fetch_queue;
  logic        clk = 0, rst = 1, flush = 0, out_ready = 1;
  logic [29:0] flush_addr = '0, imem_addr, out_pc, out_pc_next;
  logic [31:0] imem_data, out_instr;
  logic        out_valid;
  logic [2:0]  count;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  assign imem_data = 32'h1000_0000 + {2'b00, imem_addr};
  fetch_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_addr(flush_addr),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_next(out_pc_next), .count(count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    step(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_addr", imem_addr, 0);
    rst = 0;
    step();
    for (int k = 0; k < 6; k++) begin
      chk("seq_valid", out_valid, 1);
      chk("seq_count", count, 1);
      chk("seq_pc", out_pc, k);
      chk("seq_instr", out_instr, 32'h1000_0000 + k);
      chk("seq_next", out_pc_next, k + 1);
      step();
    end
    rst = 1; out_ready = 0;
    step();
    rst = 0;
    step(10);
    chk("stall_count", count, 4);
    chk("stall_addr", imem_addr, 4);
    chk("stall_head", out_pc, 0);
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_pc", out_pc, k);
      chk("drain_instr", out_instr, 32'h1000_0000 + k);
      step();
    end
    rst = 1; out_ready = 0;
    step();
    rst = 0;
    step(3);
    chk("c3_count", count, 3);
    flush = 1; flush_addr = 30'h100;
    step();
    flush = 0;
    chk("fl_valid", out_valid, 0);
    chk("fl_count", count, 0);
    chk("fl_addr", imem_addr, 30'h100);
    step();
    chk("fl_head_valid", out_valid, 1);
    chk("fl_head_pc", out_pc, 30'h100);
    chk("fl_head_instr", out_instr, 32'h1000_0100);
    step(5);
    chk("full_count", count, 4);
    out_ready = 1; flush = 1; flush_addr = 30'h200;
    step();
    flush = 0;
    chk("flfull_count", count, 0);
    chk("flfull_valid", out_valid, 0);
    chk("flfull_addr", imem_addr, 30'h200);
    step();
    chk("flfull_pc", out_pc, 30'h200);
    chk("flfull_count1", count, 1);
    step();
    chk("flfull_pc2", out_pc, 30'h201);
    flush = 1; flush_addr = 30'h3FFF_FFFE;
    step();
    flush = 0;
    step();
    chk("wrap_pc0", out_pc, 30'h3FFF_FFFE);
    chk("wrap_next0", out_pc_next, 30'h3FFF_FFFF);
    step();
    chk("wrap_pc1", out_pc, 30'h3FFF_FFFF);
    chk("wrap_next1", out_pc_next, 0);
    step();
    chk("wrap_pc2", out_pc, 0);
    chk("wrap_instr2", out_instr, 32'h1000_0000);
    flush = 1; flush_addr = 30'h10;
    step();
    flush_addr = 30'h20;
    step();
    flush = 0;
    chk("b2b_addr", imem_addr, 30'h20);
    step();
    chk("b2b_pc", out_pc, 30'h20);
    out_ready = 0;
    step();
    chk("c2_count", count, 2);
    rst = 1; flush = 1; flush_addr = 30'h55;
    step();
    rst = 0; flush = 0;
    chk("rstfl_count", count, 0);
    chk("rstfl_valid", out_valid, 0);
    chk("rstfl_addr", imem_addr, 0);
    step();
    chk("rstfl_pc", out_pc, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
